// File: rtl/stall_sequencer.sv
// Global stall controller: merges buffer-full flags and the downstream stall
// request into one registered stall, then sequences a drain window after the
// stall releases and a multi-cycle flush on request. Also keeps saturating
// stall statistics for performance debug.
module stall_sequencer #(
  parameter int NUM_BUFS     = 4,
  parameter int RESUME_DELAY = 2,
  parameter int DRAIN_CYCLES = 8,
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_BUFS-1:0] buf_full,
  input  logic                stall_req,
  input  logic                flush_req,
  input  logic                cnt_clr,
  output logic                stall_out,
  output logic                flush_out,
  output logic                upstream_hold,
  output logic [1:0]          mgr_state,
  output logic [CNT_W-1:0]    stall_cycles,
  output logic [CNT_W-1:0]    stall_events
);

  // The phase counters share one width, sized for the longest terminal value.
  localparam int MAX_AB = (RESUME_DELAY > DRAIN_CYCLES) ? RESUME_DELAY : DRAIN_CYCLES;
  localparam int MAX_ALL = (MAX_AB > FLUSH_CYCLES) ? MAX_AB : FLUSH_CYCLES;
  localparam int PW = (MAX_ALL > 1) ? $clog2(MAX_ALL) : 1;

  localparam logic [PW-1:0] RESUME_LAST = PW'(RESUME_DELAY - 1);
  localparam logic [PW-1:0] DRAIN_LAST  = PW'(DRAIN_CYCLES - 1);
  localparam logic [PW-1:0] FLUSH_LAST  = PW'(FLUSH_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_RUN   = 2'b00,
    ST_STALL = 2'b01,
    ST_DRAIN = 2'b10,
    ST_FLUSH = 2'b11
  } state_t;

  state_t state_reg, state_next;
  logic [PW-1:0] resume_cnt_reg, resume_cnt_next;
  logic [PW-1:0] drain_cnt_reg, drain_cnt_next;
  logic [PW-1:0] flush_cnt_reg, flush_cnt_next;
  logic [CNT_W-1:0] stall_cycles_reg;
  logic [CNT_W-1:0] stall_events_reg;
  logic event_inc;
  logic cause;

  // OR chain of all stall sources; bit 0 seeds it with the downstream request.
  logic [NUM_BUFS:0] cause_chain;
  assign cause_chain[0] = stall_req;
  generate
    for (genvar gi = 0; gi < NUM_BUFS; gi++) begin : g_cause
      assign cause_chain[gi+1] = cause_chain[gi] | buf_full[gi];
    end
  endgenerate
  assign cause = cause_chain[NUM_BUFS];

  // State and phase-counter registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg      <= ST_RUN;
      resume_cnt_reg <= '0;
      drain_cnt_reg  <= '0;
      flush_cnt_reg  <= '0;
    end else begin
      state_reg      <= state_next;
      resume_cnt_reg <= resume_cnt_next;
      drain_cnt_reg  <= drain_cnt_next;
      flush_cnt_reg  <= flush_cnt_next;
    end
  end

  // Next-state logic: flush request beats any cause, which beats counter expiry.
  always_comb begin
    state_next      = state_reg;
    resume_cnt_next = resume_cnt_reg;
    drain_cnt_next  = drain_cnt_reg;
    flush_cnt_next  = flush_cnt_reg;
    event_inc       = 1'b0;
    case (state_reg)
      ST_RUN: begin
        if (flush_req) begin
          state_next      = ST_FLUSH;
          resume_cnt_next = '0;
          drain_cnt_next  = '0;
          flush_cnt_next  = '0;
        end else if (cause) begin
          state_next = ST_STALL;
          event_inc  = 1'b1;
        end
      end
      ST_STALL: begin
        if (flush_req) begin
          state_next      = ST_FLUSH;
          resume_cnt_next = '0;
          drain_cnt_next  = '0;
          flush_cnt_next  = '0;
        end else if (cause) begin
          resume_cnt_next = '0;
        end else if (resume_cnt_reg == RESUME_LAST) begin
          state_next      = ST_DRAIN;
          resume_cnt_next = '0;
        end else begin
          resume_cnt_next = resume_cnt_reg + 1'b1;
        end
      end
      ST_DRAIN: begin
        if (flush_req) begin
          state_next      = ST_FLUSH;
          resume_cnt_next = '0;
          drain_cnt_next  = '0;
          flush_cnt_next  = '0;
        end else if (cause) begin
          state_next     = ST_STALL;
          event_inc      = 1'b1;
          drain_cnt_next = '0;
        end else if (drain_cnt_reg == DRAIN_LAST) begin
          state_next     = ST_RUN;
          drain_cnt_next = '0;
        end else begin
          drain_cnt_next = drain_cnt_reg + 1'b1;
        end
      end
      ST_FLUSH: begin
        // A pending cause is deliberately ignored here; RUN picks it up next cycle.
        if (flush_req) begin
          flush_cnt_next = '0;
        end else if (flush_cnt_reg == FLUSH_LAST) begin
          state_next     = ST_RUN;
          flush_cnt_next = '0;
        end else begin
          flush_cnt_next = flush_cnt_reg + 1'b1;
        end
      end
      default: state_next = ST_RUN;
    endcase
  end

  // Saturating statistics; a clear takes precedence over an increment.
  always_ff @(posedge clk) begin
    if (!reset || cnt_clr) begin
      stall_cycles_reg <= '0;
      stall_events_reg <= '0;
    end else begin
      if (state_reg == ST_STALL && stall_cycles_reg != '1)
        stall_cycles_reg <= stall_cycles_reg + 1'b1;
      if (event_inc && stall_events_reg != '1)
        stall_events_reg <= stall_events_reg + 1'b1;
    end
  end

  assign stall_out     = (state_reg == ST_STALL);
  assign upstream_hold = (state_reg != ST_RUN);
  assign flush_out     = (state_reg == ST_FLUSH);
  assign mgr_state     = state_reg;
  assign stall_cycles  = stall_cycles_reg;
  assign stall_events  = stall_events_reg;

endmodule

// File: tb/tb_stall_sequencer.sv
// Directed bench for stall_sequencer. Each vector drives one cycle of inputs
// and queues the expected post-edge response; a separate monitor pops and
// compares on the falling edge.
module tb_stall_sequencer;

  localparam int CW = 4;
  localparam logic [1:0] S_RUN   = 2'b00;
  localparam logic [1:0] S_STALL = 2'b01;
  localparam logic [1:0] S_DRAIN = 2'b10;
  localparam logic [1:0] S_FLUSH = 2'b11;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [3:0]    buf_full = '0;
  logic          stall_req = 1'b0;
  logic          flush_req = 1'b0;
  logic          cnt_clr = 1'b0;
  logic          stall_out, flush_out, upstream_hold;
  logic [1:0]    mgr_state;
  logic [CW-1:0] stall_cycles, stall_events;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int row = 0;

  typedef struct {
    int         tag;
    int         row;
    logic [1:0] st;
    logic [CW-1:0] sc;
    logic [CW-1:0] se;
  } exp_t;

  exp_t sb[$];

  stall_sequencer #(
    .NUM_BUFS(4), .RESUME_DELAY(2), .DRAIN_CYCLES(8), .FLUSH_CYCLES(2), .CNT_W(CW)
  ) dut (
    .clk(clk), .reset(reset), .buf_full(buf_full), .stall_req(stall_req),
    .flush_req(flush_req), .cnt_clr(cnt_clr), .stall_out(stall_out),
    .flush_out(flush_out), .upstream_hold(upstream_hold), .mgr_state(mgr_state),
    .stall_cycles(stall_cycles), .stall_events(stall_events)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int r, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL row=%0d %s actual=%0h expected=%0h", r, name, act, exp);
    end
  endtask

  // Monitor: compares the queued expectation belonging to this cycle.
  always @(negedge clk) begin
    if (sb.size() > 0 && sb[0].tag < cyc) begin
      checks++;
      failures++;
      $display("FAIL row=%0d missed_check actual=cycle%0d expected=cycle%0d", sb[0].row, cyc, sb[0].tag);
      void'(sb.pop_front());
    end
    if (sb.size() > 0 && sb[0].tag == cyc) begin
      exp_t e;
      e = sb.pop_front();
      $display("row %0d: state=%b stall=%b hold=%b flush=%b cycles=%0d events=%0d",
               e.row, mgr_state, stall_out, upstream_hold, flush_out, stall_cycles, stall_events);
      chk("mgr_state",     e.row, 8'(mgr_state),     8'(e.st));
      chk("stall_out",     e.row, 8'(stall_out),     8'(e.st == S_STALL));
      chk("upstream_hold", e.row, 8'(upstream_hold), 8'(e.st != S_RUN));
      chk("flush_out",     e.row, 8'(flush_out),     8'(e.st == S_FLUSH));
      chk("stall_cycles",  e.row, 8'(stall_cycles),  8'(e.sc));
      chk("stall_events",  e.row, 8'(stall_events),  8'(e.se));
    end
  end

  // One vector: inputs for this cycle and the expected response after the edge.
  task automatic v(input logic [3:0] bf, input logic sr, input logic fr, input logic cc,
                   input logic rst, input logic [1:0] st, input int sc, input int se);
    exp_t e;
    buf_full  = bf;
    stall_req = sr;
    flush_req = fr;
    cnt_clr   = cc;
    reset     = rst;
    e.tag = cyc + 1;
    e.row = row;
    e.st  = st;
    e.sc  = CW'(sc);
    e.se  = CW'(se);
    sb.push_back(e);
    row++;
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset for three cycles, then idle.
    for (int i = 0; i < 3; i++) v(4'h0, 0, 0, 0, 0, S_RUN, 0, 0);
    for (int i = 0; i < 10; i++) v(4'h0, 0, 0, 0, 1, S_RUN, 0, 0);

    // One buffer full for 5 cycles: 6 STALL cycles, 8 DRAIN cycles, RUN.
    v(4'h4, 0, 0, 0, 1, S_STALL, 0, 1);
    v(4'h4, 0, 0, 0, 1, S_STALL, 1, 1);
    v(4'h4, 0, 0, 0, 1, S_STALL, 2, 1);
    v(4'h4, 0, 0, 0, 1, S_STALL, 3, 1);
    v(4'h4, 0, 0, 0, 1, S_STALL, 4, 1);
    v(4'h0, 0, 0, 0, 1, S_STALL, 5, 1);
    v(4'h0, 0, 0, 0, 1, S_DRAIN, 6, 1);
    for (int i = 0; i < 7; i++) v(4'h0, 0, 0, 0, 1, S_DRAIN, 6, 1);
    v(4'h0, 0, 0, 0, 1, S_RUN, 6, 1);
    v(4'h0, 0, 0, 0, 1, S_RUN, 6, 1);

    // Stall request pulses inside STALL restart the resume count.
    v(4'h0, 1, 0, 0, 1, S_STALL, 6, 2);
    v(4'h0, 1, 0, 0, 1, S_STALL, 7, 2);
    v(4'h0, 0, 0, 0, 1, S_STALL, 8, 2);
    v(4'h0, 1, 0, 0, 1, S_STALL, 9, 2);
    v(4'h0, 0, 0, 0, 1, S_STALL, 10, 2);
    v(4'h0, 0, 0, 0, 1, S_DRAIN, 11, 2);

    // Stall request at drain count 3 re-enters STALL; then a full DRAIN.
    v(4'h0, 0, 0, 0, 1, S_DRAIN, 11, 2);
    v(4'h0, 0, 0, 0, 1, S_DRAIN, 11, 2);
    v(4'h0, 0, 0, 0, 1, S_DRAIN, 11, 2);
    v(4'h0, 1, 0, 0, 1, S_STALL, 11, 3);
    v(4'h0, 0, 0, 0, 1, S_STALL, 12, 3);
    v(4'h0, 0, 0, 0, 1, S_DRAIN, 13, 3);
    for (int i = 0; i < 7; i++) v(4'h0, 0, 0, 0, 1, S_DRAIN, 13, 3);
    v(4'h0, 0, 0, 0, 1, S_RUN, 13, 3);

    // Clear statistics while idle.
    v(4'h0, 0, 0, 1, 1, S_RUN, 0, 0);

    // Flush pulse in STALL with all buffers full: 2 FLUSH, 1 RUN, then STALL.
    v(4'hF, 0, 0, 0, 1, S_STALL, 0, 1);
    v(4'hF, 0, 1, 0, 1, S_FLUSH, 1, 1);
    v(4'hF, 0, 0, 0, 1, S_FLUSH, 1, 1);
    v(4'hF, 0, 0, 0, 1, S_RUN, 1, 1);
    v(4'hF, 0, 0, 0, 1, S_STALL, 1, 2);
    v(4'h0, 0, 0, 0, 1, S_STALL, 2, 2);
    v(4'h0, 0, 0, 0, 1, S_DRAIN, 3, 2);

    // Flush held 4 cycles from DRAIN: flush_out high for 5 cycles.
    for (int i = 0; i < 4; i++) v(4'h0, 0, 1, 0, 1, S_FLUSH, 3, 2);
    v(4'h0, 0, 0, 0, 1, S_FLUSH, 3, 2);
    v(4'h0, 0, 0, 0, 1, S_RUN, 3, 2);

    // Long stall saturates the 4-bit cycle counter at 15.
    v(4'h1, 0, 0, 0, 1, S_STALL, 3, 3);
    for (int k = 2; k <= 19; k++) v(4'h1, 0, 0, 0, 1, S_STALL, (k + 2 > 15) ? 15 : k + 2, 3);

    // Clear coincident with an increment wins, then counting resumes.
    v(4'h1, 0, 0, 1, 1, S_STALL, 0, 0);
    v(4'h1, 0, 0, 0, 1, S_STALL, 1, 0);
    v(4'h0, 0, 0, 0, 1, S_STALL, 2, 0);
    v(4'h0, 0, 0, 0, 1, S_DRAIN, 3, 0);
    v(4'h0, 0, 0, 0, 1, S_DRAIN, 3, 0);
    v(4'h0, 0, 0, 0, 1, S_DRAIN, 3, 0);

    // Reset mid-DRAIN and mid-FLUSH returns to RUN with everything cleared.
    v(4'h0, 1, 0, 0, 0, S_RUN, 0, 0);
    v(4'h0, 0, 0, 0, 1, S_RUN, 0, 0);
    v(4'h0, 0, 1, 0, 1, S_FLUSH, 0, 0);
    v(4'h0, 0, 1, 0, 0, S_RUN, 0, 0);
    v(4'h0, 0, 0, 0, 1, S_RUN, 0, 0);

    @(negedge clk);
    @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain actual=%0d expected=0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
